mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO register width (even, >= 8).
REQ-002 SHALL have parameter MUL_LAT, default 5, busy cycles per multiply-class op (>= 1).
REQ-003 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: req  in  1  exception/interrupt pending; blocks acceptance of new ops.
REQ-006 SHALL have ports: start  in  1  op valid this cycle.
REQ-007 SHALL have ports: op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 treated as NONE.
REQ-008 SHALL have ports: rs, rt  in  WIDTH each  operands; MTHI/MTLO write rs.
REQ-009 SHALL have ports: hi_sel  in  1  read select, 1 = HI, 0 = LO.
REQ-010 SHALL have ports: busy  out  1  registered, op in flight.
REQ-011 SHALL have ports: result  out  WIDTH  combinational, hi_sel ? HI : LO.
REQ-012 SHALL have ports: div_zero  out  1  registered, one-cycle pulse at completion of a divide by zero.

Function
REQ-013 SHALL accept an op only on an edge where start=1, busy=0, req=0; otherwise op is ignored without side effects.
REQ-014 SHALL commit MTHI/MTLO to HI/LO on the accepting edge, busy stays 0.
REQ-015 SHALL on accepting MULT/MULTU raise busy for exactly MUL_LAT cycles, then on the edge busy falls write {HI,LO} = full 2*WIDTH product (signed or unsigned).
REQ-016 SHALL on accepting DIV/DIVU raise busy for exactly WIDTH+1 cycles via the iterative divider, then on the edge busy falls write LO = quotient, HI = remainder.
REQ-017 SHALL truncate signed quotient toward zero; remainder takes dividend sign; most-negative / -1 yields LO = most-negative, HI = 0.
REQ-018 SHALL for divisor 0 still run the full WIDTH+1 busy cycles, leave HI/LO unchanged, pulse div_zero with the busy-falling edge.
REQ-019 SHALL keep result reflecting committed HI/LO during busy (old values until commit).
REQ-020 SHALL once accepted, complete an op regardless of req or start; req never aborts an in-flight op.
REQ-021 SHALL latch operands and op at acceptance; later changes to rs/rt/op do not affect the op.
REQ-022 SHALL allow a new op to be accepted on the cycle after busy falls (no bubble beyond that).
REQ-023 SHALL implement busy counting with an internal FSM: IDLE, MUL, DIV, with IDLE->MUL/DIV on acceptance and back to IDLE on count expiry.

Reset
REQ-024 SHALL on reset=0 asynchronously clear HI, LO, busy, div_zero, counters, FSM to IDLE, irrespective of in-flight op.
REQ-025 SHALL resume normal acceptance on the first edge after reset deasserts.

Configuration
REQ-026 SHALL with MUL_DIV_ACC_EN defined support MADD/MADDU/MSUB/MSUBU: {HI,LO} +/- product modulo 2^(2*WIDTH), same latency as MULT.
REQ-027 SHALL without MUL_DIV_ACC_EN treat ops 7-10 as NONE (no busy, no HI/LO change).

Structure
REQ-028 SHALL place op encoding constants and FSM state typedef in shared package mul_div_pkg.
REQ-029 SHALL implement division in one sub-module mul_div_divider (restoring, one quotient bit per cycle, magnitude domain, sign fix-up on final cycle).
REQ-030 SHALL compute multiply product at acceptance and hold it in a pipeline register until commit.

Verification
REQ-031 SHALL cover: MULT rs=-3, rt=7 -> busy 5 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-032 SHALL cover: DIVU rs=100, rt=7 -> busy 33 cycles, LO=14, HI=2; DIV rs=-7, rt=2 -> LO=-3, HI=-1.
REQ-033 SHALL cover: DIV rt=0 with HI=5, LO=9 -> HI/LO unchanged, div_zero high one cycle at busy fall.
REQ-034 SHALL cover: start MTHI rs=0x1234 with req=1 -> ignored; same with req=0 -> HI=0x1234 next edge, busy 0.
REQ-035 SHALL cover: reset low mid-DIV cycle 10 -> busy, HI, LO = 0 immediately, no commit after release.
REQ-036 SHALL cover: MUL_DIV_ACC_EN, HI=0, LO=0xFFFFFFFF, MADDU 1*1 -> HI=1, LO=0; without macro -> no change, busy never set.

Source files
------------

// File: rtl/mul_div_pkg.sv
// mul_div_pkg: op encodings, FSM state constants and op helpers.
// Shared by the interface, the top mul_div_unit and the divider.
package mul_div_pkg;

  typedef logic [3:0] op_t;

  localparam op_t OP_NONE  = 4'd0;
  localparam op_t OP_MULT  = 4'd1;
  localparam op_t OP_MULTU = 4'd2;
  localparam op_t OP_DIV   = 4'd3;
  localparam op_t OP_DIVU  = 4'd4;
  localparam op_t OP_MTHI  = 4'd5;
  localparam op_t OP_MTLO  = 4'd6;
  localparam op_t OP_MADD  = 4'd7;
  localparam op_t OP_MADDU = 4'd8;
  localparam op_t OP_MSUB  = 4'd9;
  localparam op_t OP_MSUBU = 4'd10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;

  function automatic logic op_signed(op_t op);
    return (op == OP_MULT) || (op == OP_DIV) ||
           (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_acc(op_t op);
    return (op == OP_MADD) || (op == OP_MADDU) ||
           (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic op_sub(op_t op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/mul_div_if.sv
// mul_div_if: request/operand bus and HI/LO read-back of mul_div_unit.
// master drives ops and hi_sel; slave returns busy, result, div_zero.
interface mul_div_if
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             req;
  logic             start;
  op_t              op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             hi_sel;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             div_zero;

  modport master (
    output req, start, op, rs, rt, hi_sel,
    input  busy, result, div_zero
  );

  modport slave (
    input  req, start, op, rs, rt, hi_sel,
    output busy, result, div_zero
  );

endinterface

// File: rtl/mul_div_divider.sv
// mul_div_divider: restoring divider, one quotient bit per step,
// magnitudes internally, signs applied on the outputs.
module mul_div_divider
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dvd,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_qneg;
  logic             r_rneg;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  assign w_dvd_neg = i_signed & i_dvd[WIDTH-1];
  assign w_dvs_neg = i_signed & i_dvs[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -i_dvd : i_dvd;
  assign w_dvs_mag = w_dvs_neg ? -i_dvs : i_dvs;
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};

  // load magnitudes, then shift in one quotient bit per step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (i_load) begin
      r_quo  <= w_dvd_mag;
      r_rem  <= '0;
      r_dvs  <= w_dvs_mag;
      r_qneg <= w_dvd_neg ^ w_dvs_neg;
      r_rneg <= w_dvd_neg;
    end else if (i_step) begin
      if (!w_diff[WIDTH]) begin
        r_rem <= w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign o_quo = r_qneg ? -r_quo : r_quo;
  assign o_rem = r_rneg ? -r_rem : r_rem;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: HI/LO multiply/divide unit with busy FSM.
// Define MUL_DIV_ACC_EN to enable MADD/MADDU/MSUB/MSUBU.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input logic   clk,
  input logic   reset,
  mul_div_if.slave bus
);

  localparam int DW   = 2 * WIDTH;
  localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  state_t           r_state;
  logic             r_busy;
  logic             r_dz;
  logic             r_dvz;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [DW-1:0]    r_prod;
`ifdef MUL_DIV_ACC_EN
  logic             r_acc;
  logic             r_sub;
`endif

  logic             w_accept;
  logic             w_sgn;
  logic             w_acc;
  logic             w_mul;
  logic             w_div;
  logic             w_mth;
  logic             w_mtl;
  logic [DW-1:0]    w_a;
  logic [DW-1:0]    w_b;
  logic [DW-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_accept = bus.start & ~r_busy & ~bus.req;
  assign w_sgn    = op_signed(bus.op);
`ifdef MUL_DIV_ACC_EN
  assign w_acc    = op_acc(bus.op);
`else
  assign w_acc    = 1'b0;
`endif
  assign w_mul    = (bus.op == OP_MULT) | (bus.op == OP_MULTU) | w_acc;
  assign w_div    = (bus.op == OP_DIV) | (bus.op == OP_DIVU);
  assign w_mth    = (bus.op == OP_MTHI);
  assign w_mtl    = (bus.op == OP_MTLO);

  assign w_a    = {{WIDTH{w_sgn & bus.rs[WIDTH-1]}}, bus.rs};
  assign w_b    = {{WIDTH{w_sgn & bus.rt[WIDTH-1]}}, bus.rt};
  assign w_prod = w_a * w_b;

  mul_div_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_accept & w_div),
    .i_step   ((r_state == ST_DIV) && (r_cnt != '0)),
    .i_signed (w_sgn),
    .i_dvd    (bus.rs),
    .i_dvs    (bus.rt),
    .o_quo    (w_quo),
    .o_rem    (w_rem)
  );

  // accept ops, count busy cycles, commit HI/LO on busy fall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_dz    <= 1'b0;
      r_dvz   <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_prod  <= '0;
`ifdef MUL_DIV_ACC_EN
      r_acc   <= 1'b0;
      r_sub   <= 1'b0;
`endif
    end else begin
      r_dz <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            unique case (1'b1)
              w_mth: r_hi <= bus.rs;
              w_mtl: r_lo <= bus.rs;
              w_mul: begin
                r_state <= ST_MUL;
                r_busy  <= 1'b1;
                r_cnt   <= CW'(MUL_LAT - 1);
                r_prod  <= w_prod;
`ifdef MUL_DIV_ACC_EN
                r_acc   <= w_acc;
                r_sub   <= op_sub(bus.op);
`endif
              end
              w_div: begin
                r_state <= ST_DIV;
                r_busy  <= 1'b1;
                r_cnt   <= CW'(WIDTH);
                r_dvz   <= (bus.rt == '0);
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`ifdef MUL_DIV_ACC_EN
            if (r_acc && r_sub)
              {r_hi, r_lo} <= {r_hi, r_lo} - r_prod;
            else if (r_acc)
              {r_hi, r_lo} <= {r_hi, r_lo} + r_prod;
            else
              {r_hi, r_lo} <= r_prod;
`else
            {r_hi, r_lo} <= r_prod;
`endif
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DIV: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (r_dvz) begin
              r_dz <= 1'b1;
            end else begin
              r_lo <= w_quo;
              r_hi <= w_rem;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.div_zero = r_dz;
  assign bus.result   = bus.hi_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random ops against an arithmetic
// HI/LO model; honours MUL_DIV_ACC_EN like the design.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int W    = 32;
  localparam int LAT  = 5;
  localparam int DLAT = W + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mul_div_if #(.WIDTH(W)) bus();

  mul_div_unit #(
    .WIDTH   (W),
    .MUL_LAT (LAT)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_hl(output logic [W-1:0] h, output logic [W-1:0] l);
    bus.hi_sel = 1'b1;
    #1 h = bus.result;
    bus.hi_sel = 1'b0;
    #1 l = bus.result;
  endtask

  // expected HI/LO, busy length and div_zero from plain arithmetic
  task automatic model(input op_t op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic rq,
                       output int lat, output logic dz);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned p;
    logic [63:0]     acc;
    lat = 0;
    dz  = 1'b0;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = a;
    ub  = b;
    if (rq) return;
    acc = {m_hi, m_lo};
    case (op)
      OP_MULT:  begin p = sa * sb; {m_hi, m_lo} = p; lat = LAT; end
      OP_MULTU: begin p = ua * ub; {m_hi, m_lo} = p; lat = LAT; end
      OP_DIV: begin
        lat = DLAT;
        if (b == 0) dz = 1'b1;
        else begin m_lo = W'(sa / sb); m_hi = W'(sa % sb); end
      end
      OP_DIVU: begin
        lat = DLAT;
        if (b == 0) dz = 1'b1;
        else begin m_lo = W'(ua / ub); m_hi = W'(ua % ub); end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
`ifdef MUL_DIV_ACC_EN
      OP_MADD:  begin p = sa * sb; {m_hi, m_lo} = acc + p; lat = LAT; end
      OP_MADDU: begin p = ua * ub; {m_hi, m_lo} = acc + p; lat = LAT; end
      OP_MSUB:  begin p = sa * sb; {m_hi, m_lo} = acc - p; lat = LAT; end
      OP_MSUBU: begin p = ua * ub; {m_hi, m_lo} = acc - p; lat = LAT; end
`endif
      default: ;
    endcase
  endtask

  task automatic run_op(input string tag, input op_t op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic rq);
    int           lat;
    int           elat;
    logic         edz;
    logic [W-1:0] h;
    logic [W-1:0] l;
    logic [W-1:0] oh;
    logic [W-1:0] ol;
    oh = m_hi;
    ol = m_lo;
    model(op, a, b, rq, elat, edz);
    bus.req   = rq;
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs    = a;
    bus.rt    = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 4'($urandom);
    bus.rs    = $urandom;
    bus.rt    = $urandom;
    bus.req   = 1'($urandom);
    chk({tag, ".dz_low"}, 64'(bus.div_zero), 64'h0);
    lat = 0;
    if (bus.busy === 1'b1) begin
      read_hl(h, l);
      chk({tag, ".old_hi"}, 64'(h), 64'(oh));
      chk({tag, ".old_lo"}, 64'(l), 64'(ol));
    end
    while (bus.busy === 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".busy_len"}, 64'(lat), 64'(elat));
    if (elat > 0)
      chk({tag, ".dz_fall"}, 64'(bus.div_zero), 64'(edz));
    bus.req = 1'b0;
    read_hl(h, l);
    chk({tag, ".hi"}, 64'(h), 64'(m_hi));
    chk({tag, ".lo"}, 64'(l), 64'(m_lo));
  endtask

  initial begin
    logic [W-1:0] h;
    logic [W-1:0] l;
    op_t          rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rrq;

    bus.req    = 1'b0;
    bus.start  = 1'b0;
    bus.op     = OP_NONE;
    bus.rs     = '0;
    bus.rt     = '0;
    bus.hi_sel = 1'b0;

    #12;
    chk("rst.busy", 64'(bus.busy), 64'h0);
    chk("rst.dz", 64'(bus.div_zero), 64'h0);
    read_hl(h, l);
    chk("rst.hi", 64'(h), 64'h0);
    chk("rst.lo", 64'(l), 64'h0);
    rst_n = 1'b1;

    run_op("mult", OP_MULT, -3, 7, 1'b0);
    read_hl(h, l);
    chk("mult.hi_k", 64'(h), 64'hFFFF_FFFF);
    chk("mult.lo_k", 64'(l), 64'hFFFF_FFEB);

    run_op("divu", OP_DIVU, 100, 7, 1'b0);
    read_hl(h, l);
    chk("divu.lo_k", 64'(l), 64'd14);
    chk("divu.hi_k", 64'(h), 64'd2);

    run_op("div", OP_DIV, -7, 2, 1'b0);
    read_hl(h, l);
    chk("div.lo_k", 64'(l), 64'hFFFF_FFFD);
    chk("div.hi_k", 64'(h), 64'hFFFF_FFFF);

    run_op("mthi5", OP_MTHI, 5, 0, 1'b0);
    run_op("mtlo9", OP_MTLO, 9, 0, 1'b0);
    run_op("div0", OP_DIV, 123, 0, 1'b0);
    read_hl(h, l);
    chk("div0.hi_k", 64'(h), 64'd5);
    chk("div0.lo_k", 64'(l), 64'd9);

    run_op("mthi_req", OP_MTHI, 32'h1234, 0, 1'b1);
    run_op("mthi", OP_MTHI, 32'h1234, 0, 1'b0);
    read_hl(h, l);
    chk("mthi.hi_k", 64'(h), 64'h1234);

    run_op("ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    read_hl(h, l);
    chk("ovf.lo_k", 64'(l), 64'h8000_0000);
    chk("ovf.hi_k", 64'(h), 64'h0);

    run_op("op13", 4'd13, 32'h55, 32'h66, 1'b0);

    bus.req   = 1'b0;
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.rs    = 32'd1000;
    bus.rt    = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("rstdiv.busy_pre", 64'(bus.busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstdiv.busy", 64'(bus.busy), 64'h0);
    chk("rstdiv.dz", 64'(bus.div_zero), 64'h0);
    read_hl(h, l);
    chk("rstdiv.hi", 64'(h), 64'h0);
    chk("rstdiv.lo", 64'(l), 64'h0);
    rst_n = 1'b1;
    m_hi  = '0;
    m_lo  = '0;
    repeat (40) @(posedge clk);
    #1;
    chk("rstdiv.busy_post", 64'(bus.busy), 64'h0);
    read_hl(h, l);
    chk("rstdiv.hi_post", 64'(h), 64'h0);
    chk("rstdiv.lo_post", 64'(l), 64'h0);

    run_op("acc_hi", OP_MTHI, 0, 0, 1'b0);
    run_op("acc_lo", OP_MTLO, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("maddu", OP_MADDU, 1, 1, 1'b0);
    read_hl(h, l);
`ifdef MUL_DIV_ACC_EN
    chk("maddu.hi_k", 64'(h), 64'h1);
    chk("maddu.lo_k", 64'(l), 64'h0);
`else
    chk("maddu.hi_k", 64'(h), 64'h0);
    chk("maddu.lo_k", 64'(l), 64'hFFFF_FFFF);
`endif

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 9);
      if ($urandom_range(0, 7) == 0) rb = '0;
      rrq = ($urandom_range(0, 4) == 0);
      run_op("rnd", rop, ra, rb, rrq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
